// File: rtl/shared_bus_arbiter.sv
// Two-port round-robin owner of the shared RAM1/UART data bus; generates all strobes.
// Define BUS_TIMEOUT_EN to bound the UART wait states by TIMEOUT_CYC cycles.
module shared_bus_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int STROBE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_wdata,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  inout  wire  [7:0]        data,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic              wrn,
  output logic              rdn,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre
);

  localparam int DATA_W = 8;
  localparam logic [1:0] OP_UART_RD = 2'b00;
  localparam logic [1:0] OP_UART_WR = 2'b01;
  localparam logic [3:0] STB_LAST   = 4'(STROBE_CYC - 1);

  if (STROBE_CYC < 1 || STROBE_CYC > 15 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("shared_bus_arbiter: STROBE_CYC must be 1..15 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACCEPT,
    S_SETUP,
    S_WAIT_DR,
    S_STROBE,
    S_HOLD,
    S_WAIT_TBRE,
    S_WAIT_TSRE,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic              rr_ptr;
  logic              grant_id;
  logic              grant_next;
  logic              any_valid;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        stb_cnt;
  logic              stb_last;
  logic              is_ram;
  logic              is_wr;
  logic              drive_en;
  logic              timeout;

  // Round-robin choice is only consulted when both ports are requesting.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_next = (req0_valid && req1_valid) ? rr_ptr : req1_valid;

  assign sel_op    = grant_id ? req1_op    : req0_op;
  assign sel_addr  = grant_id ? req1_addr  : req0_addr;
  assign sel_wdata = grant_id ? req1_wdata : req0_wdata;

  assign is_ram   = op_q[1];
  assign is_wr    = op_q[0];
  assign stb_last = (stb_cnt == STB_LAST);

`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait;
  logic              wait_met;
  logic              err_q;

  assign in_wait  = (state == S_WAIT_DR) || (state == S_WAIT_TBRE) || (state == S_WAIT_TSRE);
  assign wait_met = ((state == S_WAIT_DR)   && data_ready) ||
                    ((state == S_WAIT_TBRE) && tbre) ||
                    ((state == S_WAIT_TSRE) && tsre);
  assign timeout  = in_wait && !wait_met && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  // Counter restarts on every state entry, so each wait state gets its own budget.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state)) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_ACCEPT) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (any_valid) state_next = S_ACCEPT;
      S_ACCEPT:    state_next = (sel_op == OP_UART_RD) ? S_WAIT_DR : S_SETUP;
      S_WAIT_DR: begin
        if (data_ready)   state_next = S_STROBE;
        else if (timeout) state_next = S_DONE;
      end
      S_SETUP:     state_next = S_STROBE;
      S_STROBE:    if (stb_last) state_next = S_HOLD;
      S_HOLD:      state_next = (op_q == OP_UART_WR) ? S_WAIT_TBRE : S_DONE;
      S_WAIT_TBRE: begin
        if (tbre)         state_next = S_WAIT_TSRE;
        else if (timeout) state_next = S_DONE;
      end
      S_WAIT_TSRE: if (tsre || timeout) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Every strobe is a decode of the state register alone, so a reset edge clears them all at once.
  always_comb begin
    busy       = (state != S_IDLE);
    req0_ready = (state == S_ACCEPT) && !grant_id;
    req1_ready = (state == S_ACCEPT) && grant_id;
    rsp_valid  = (state == S_DONE);
    ram1_en    = 1'b1;
    ram1_oe    = 1'b1;
    ram1_we    = 1'b1;
    wrn        = 1'b1;
    rdn        = 1'b1;
    drive_en   = 1'b0;
    if ((state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD)) begin
      ram1_en  = !is_ram;
      drive_en = is_wr;
    end
    if (state == S_STROBE) begin
      ram1_oe = !(is_ram && !is_wr);
      ram1_we = !(is_ram && is_wr);
      wrn     = !(!is_ram && is_wr);
      rdn     = !(!is_ram && !is_wr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      grant_id <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      stb_cnt  <= '0;
    end else begin
      if ((state == S_IDLE) && any_valid) begin
        grant_id <= grant_next;
        rr_ptr   <= ~grant_next;
      end
      if (state == S_ACCEPT) begin
        op_q    <= sel_op;
        wdata_q <= sel_wdata;
        rdata_q <= '0;
        if (sel_op[1]) addr_q <= sel_addr;
      end
      stb_cnt <= (state == S_STROBE) ? stb_cnt + 1'b1 : '0;
      // Read data is taken on the edge that ends the last strobe cycle.
      if ((state == S_STROBE) && stb_last && !is_wr) begin
        rdata_q <= data;
      end
    end
  end

  assign data      = drive_en ? wdata_q : 8'hzz;
  assign ram1_addr = addr_q;
  assign rsp_id    = grant_id;
  assign rsp_rdata = rdata_q;

endmodule
